// File: rtl/systolic_result_streamer.sv
// Requantizes per-lane int32 accumulations to int8, packs them into words and streams them out
// over AXI-Stream. A word FIFO absorbs DMA backpressure and throttles the array via in_ready.
module systolic_result_streamer #(
  parameter int unsigned LANES      = 8,
  parameter int unsigned ACC_W      = 32,
  parameter int unsigned FIFO_DEPTH = 64,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4:0]             cfg_shift,
  input  logic [CNT_W-1:0]       cfg_total_words,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*ACC_W-1:0] in_data,
  output logic [8*LANES-1:0]     m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic                   busy,
  output logic                   done,
  output logic                   sat_seen
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned DW = 8 * LANES;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e           r_state;
  logic [4:0]       r_shift;
  logic [CNT_W-1:0] r_total;
  logic [CNT_W-1:0] r_in_cnt;
  logic [CNT_W-1:0] r_out_cnt;
  logic             r_sat;
  logic             r_pipe_valid;
  logic [DW-1:0]    r_pipe_data;
  logic [DW-1:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;

  logic [8:0]       w_rq [LANES];
  logic [DW-1:0]    w_q_data;
  logic             w_q_sat;
  logic             w_accept;
  logic             w_pop;
  logic             w_last_pop;

  // Returns {saturated, int8}; the rounding add is done one bit wider so it cannot wrap.
  function automatic logic [8:0] requant(input logic [ACC_W-1:0] acc, input logic [4:0] sh);
    logic signed [ACC_W:0] sum;
    logic signed [ACC_W:0] shd;
    logic signed [ACC_W:0] rnd;
    logic signed [ACC_W:0] max_v;
    logic signed [ACC_W:0] min_v;
    max_v = 127;
    min_v = -128;
    rnd   = '0;
    if (sh != 5'd0) rnd[sh - 5'd1] = 1'b1;
    sum = $signed({acc[ACC_W-1], acc}) + rnd;
    shd = sum >>> sh;
    if (shd > max_v)      requant = {1'b1, 8'h7f};
    else if (shd < min_v) requant = {1'b1, 8'h80};
    else                  requant = {1'b0, shd[7:0]};
  endfunction

  always_comb begin
    w_q_data = '0;
    w_q_sat  = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      w_rq[i]              = requant(in_data[ACC_W*i +: ACC_W], r_shift);
      w_q_data[8*i +: 8]   = w_rq[i][7:0];
      w_q_sat              = w_q_sat | w_rq[i][8];
    end
  end

  // Room is reserved for the word already sitting in the pipeline register.
  assign in_ready = (r_state == StRun) && (r_in_cnt < r_total) &&
                    ((r_count + CW'(r_pipe_valid)) < CW'(FIFO_DEPTH));

  assign w_accept      = in_valid && in_ready;
  assign m_axis_tvalid = (r_count != '0);
  assign m_axis_tdata  = r_mem[r_rptr];
  assign w_pop         = m_axis_tvalid && m_axis_tready;
  assign m_axis_tlast  = m_axis_tvalid && (r_out_cnt == r_total - CNT_W'(1));
  assign w_last_pop    = w_pop && m_axis_tlast;
  assign busy          = (r_state == StRun) || (r_state == StDrain);
  assign done          = (r_state == StDone);
  assign sat_seen      = r_sat;

  always_ff @(posedge clk) begin
    if (r_pipe_valid) r_mem[r_wptr] <= r_pipe_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_shift      <= '0;
      r_total      <= '0;
      r_in_cnt     <= '0;
      r_out_cnt    <= '0;
      r_sat        <= 1'b0;
      r_pipe_valid <= 1'b0;
      r_pipe_data  <= '0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
    end else begin
      r_pipe_valid <= w_accept;
      if (w_accept) begin
        r_pipe_data <= w_q_data;
        r_in_cnt    <= r_in_cnt + CNT_W'(1);
        if (w_q_sat) r_sat <= 1'b1;
      end
      if (r_pipe_valid) r_wptr <= r_wptr + AW'(1);
      if (w_pop) begin
        r_rptr    <= r_rptr + AW'(1);
        r_out_cnt <= r_out_cnt + CNT_W'(1);
      end
      case ({r_pipe_valid, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase

      case (r_state)
        StIdle: begin
          if (start) begin
            r_shift   <= cfg_shift;
            r_total   <= cfg_total_words;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
            r_sat     <= 1'b0;
            r_state   <= (cfg_total_words == '0) ? StDone : StRun;
          end
        end
        StRun:   if (r_in_cnt == r_total) r_state <= StDrain;
        StDrain: if (w_last_pop) r_state <= StDone;
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_result_streamer.sv
// Directed bench for systolic_result_streamer: layer streaming, rounding/saturation,
// backpressure, zero-length layers, ignored starts and mid-layer reset.
module tb_systolic_result_streamer;

  localparam int LANES = 8;
  localparam int ACC_W = 32;
  localparam int DEPTH = 64;
  localparam int CNT_W = 32;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start;
  logic [4:0]             cfg_shift;
  logic [CNT_W-1:0]       cfg_total_words;
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*ACC_W-1:0] in_data;
  logic [8*LANES-1:0]     m_axis_tdata;
  logic                   m_axis_tvalid;
  logic                   m_axis_tready;
  logic                   m_axis_tlast;
  logic                   busy;
  logic                   done;
  logic                   sat_seen;

  int vectors = 0;
  int miscompares = 0;

  logic [LANES*ACC_W-1:0] beats [$];
  logic [63:0]            exp_q [$];

  systolic_result_streamer #(
    .LANES(LANES), .ACC_W(ACC_W), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_shift(cfg_shift),
    .cfg_total_words(cfg_total_words), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .busy(busy), .done(done),
    .sat_seen(sat_seen)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference: floor((acc + 2^(sh-1)) / 2^sh) computed in 64-bit, then clamped.
  function automatic logic [7:0] model_lane(input int acc, input int sh);
    longint v;
    v = longint'(acc);
    if (sh > 0) v = v + (longint'(1) << (sh - 1));
    v = v >>> sh;
    if (v > 127)  return 8'h7f;
    if (v < -128) return 8'h80;
    return v[7:0];
  endfunction

  task automatic gen(input int kind, input int total, input int sh);
    int          t2 [4];
    logic [7:0]  e2 [4];
    logic [LANES*ACC_W-1:0] b;
    logic [63:0] e;
    int          v;
    t2 = '{24, -24, 40000, -40000};
    e2 = '{8'h02, 8'hff, 8'h7f, 8'h80};
    beats.delete();
    exp_q.delete();
    for (int w = 0; w < total; w++) begin
      b = '0;
      e = '0;
      if (kind == 0) begin
        b = {32'sd7, 32'sd6, 32'sd5, -32'sd128, 32'sd127, -32'sd1, 32'sd1, 32'sd0};
        e = 64'h0706_0580_7fff_0100;
      end else if (kind == 1) begin
        b[31:0] = t2[w];
        e[7:0]  = e2[w];
      end else begin
        for (int i = 0; i < LANES; i++) begin
          v = int'($urandom) >>> $urandom_range(0, 24);
          b[32*i +: 32] = v;
          e[8*i +: 8]   = model_lane(v, sh);
        end
      end
      beats.push_back(b);
      exp_q.push_back(e);
    end
  endtask

  task automatic run_layer(input int total, input int sh, input int rdy_pct, input int vld_pct,
                           input int hold, input int abort_at, input bit do_start);
    int sent, rcv, cyc, first_acc, first_val;
    bit took, prev_stall;
    logic [63:0] prev_d;
    if (do_start) begin
      start = 1'b1; cfg_shift = 5'(sh); cfg_total_words = total;
      @(posedge clk); #1;
      start = 1'b0;
    end
    sent = 0; rcv = 0; cyc = 0; took = 1'b1; prev_stall = 1'b0; prev_d = '0;
    first_acc = -1; first_val = -1;
    in_valid = 1'b0;
    while (rcv < total && cyc < 20000) begin
      if (!in_valid || took) in_valid = (sent < total) && ($urandom_range(0, 99) < vld_pct);
      in_data = (sent < total) ? beats[sent] : '0;
      m_axis_tready = (cyc >= hold) && ($urandom_range(0, 99) < rdy_pct);
      @(negedge clk);
      if (prev_stall) begin
        chk("stall_tvalid", m_axis_tvalid, 1'b1);
        chk("stall_tdata", m_axis_tdata, prev_d);
      end
      if (first_val < 0 && m_axis_tvalid) first_val = cyc;
      took = in_valid && in_ready;
      if (took) begin
        if (first_acc < 0) first_acc = cyc;
        sent++;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        chk($sformatf("tdata[%0d]", rcv), m_axis_tdata, exp_q[rcv]);
        chk($sformatf("tlast[%0d]", rcv), m_axis_tlast, (rcv == total - 1));
        rcv++;
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_d     = m_axis_tdata;
      if (hold > 0 && cyc == hold - 1) begin
        chk("buffered_words", sent, DEPTH);
        chk("full_in_ready", in_ready, 1'b0);
      end
      @(posedge clk); #1;
      cyc++;
      if (abort_at >= 0 && rcv == abort_at) begin
        rst = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        chk("rst_tvalid", m_axis_tvalid, 1'b0);
        chk("rst_tlast", m_axis_tlast, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_sat", sat_seen, 1'b0);
        rst = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    chk("words_out", rcv, total);
    if (first_acc >= 0 && first_val >= 0) chk("latency", first_val - first_acc, 2);
    @(negedge clk);
    chk("done_pulse", done, 1'b1);
    chk("busy_in_done", busy, 1'b0);
    chk("tvalid_after", m_axis_tvalid, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("done_single", done, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cfg_shift = '0; cfg_total_words = '0;
    in_valid = 1'b0; in_data = '0; m_axis_tready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_tvalid", m_axis_tvalid, 1'b0);
    chk("rst_tlast", m_axis_tlast, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_sat", sat_seen, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic layer, shift 0, no saturation.
    gen(0, 4, 0);
    run_layer(4, 0, 100, 100, 0, -1, 1'b1);
    chk("t1_sat", sat_seen, 1'b0);

    // Rounding and saturation on lane 0.
    gen(1, 4, 4);
    run_layer(4, 4, 100, 100, 0, -1, 1'b1);
    chk("t2_sat", sat_seen, 1'b1);

    // Full backpressure then drain.
    gen(2, 200, 3);
    run_layer(200, 3, 100, 100, 150, -1, 1'b1);

    // Random ready and valid gaps.
    gen(2, 300, 10);
    run_layer(300, 10, 50, 70, 0, -1, 1'b1);

    // Zero-length layer.
    start = 1'b1; cfg_shift = 5'd0; cfg_total_words = 0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("zero_done", done, 1'b1);
    chk("zero_tvalid", m_axis_tvalid, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("zero_done_single", done, 1'b0);
    @(posedge clk); #1;

    // A second start while busy must not relatch cfg or end the layer.
    gen(2, 3, 0);
    start = 1'b1; cfg_shift = 5'd0; cfg_total_words = 3;
    @(posedge clk); #1;
    cfg_shift = 5'd7; cfg_total_words = 0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("busy_start_busy", busy, 1'b1);
    chk("busy_start_done", done, 1'b0);
    @(posedge clk); #1;
    run_layer(3, 0, 100, 100, 0, -1, 1'b0);

    // Reset after 10 of 64 words, then a clean layer.
    gen(2, 64, 5);
    run_layer(64, 5, 100, 100, 0, 10, 1'b1);
    @(posedge clk); #1;
    gen(0, 4, 0);
    run_layer(4, 0, 100, 100, 0, -1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
